rom_burst_reader: RTL

Parametrised successor to the team's 8-entry constant ROM. Adds configurable width and depth, a formula-defined content table, single-word reads and auto-incrementing burst reads with address wrap, a valid/done output handshake, and an optional output pipeline stage. It sits between control logic and datapath consumers that need table data streamed one word per cycle.

---
 rtl/rom_burst_reader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/rom_burst_reader.sv
`default_nettype none
// ============================================================================
// rom_burst_reader
// Formula-initialised ROM with single-word and wrapping burst reads,
// valid/done handshake and an optional output register stage.
// Revision: 1.0
// ============================================================================
module rom_burst_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int INIT_OFFSET = 1,
  parameter int OUT_REG     = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  burst_start,
  input  logic [ADDR_WIDTH:0]   burst_len,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] rom_out,
  output logic                  rom_valid,
  output logic                  burst_done
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_BURST = 1'b1;
  localparam logic [ADDR_WIDTH:0] c_LEN_ONE = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] w_rom [c_DEPTH];

  // Content is word[i] = i + INIT_OFFSET, truncated to the word width
  generate
    for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_rom
      assign w_rom[gi] = DATA_WIDTH'(gi + INIT_OFFSET);
    end
  endgenerate

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic                  r_s1_valid;
  logic                  r_s1_last;
  logic [DATA_WIDTH-1:0] r_s1_data;

  logic [0:0]            w_next_state;
  logic [ADDR_WIDTH-1:0] w_next_cur;
  logic [ADDR_WIDTH:0]   w_next_rem;
  logic                  w_issue;
  logic                  w_issue_last;
  logic [ADDR_WIDTH-1:0] w_issue_addr;

  always_comb begin
    w_next_state = r_state;
    w_next_cur   = r_cur_addr;
    w_next_rem   = r_remaining;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_issue_addr = addr;
    if (r_state == c_BURST) begin
      w_issue      = 1'b1;
      w_issue_addr = r_cur_addr;
      w_next_cur   = r_cur_addr + 1'b1;
      w_next_rem   = r_remaining - 1'b1;
      if (r_remaining == c_LEN_ONE) begin
        w_issue_last = 1'b1;
        w_next_state = c_IDLE;
      end
    end else if (burst_start && (burst_len != '0)) begin
      w_issue    = 1'b1;
      w_next_cur = addr + 1'b1;
      w_next_rem = burst_len - 1'b1;
      // A one-word burst completes on its first read without entering BURST
      if (burst_len == c_LEN_ONE) begin
        w_issue_last = 1'b1;
      end else begin
        w_next_state = c_BURST;
      end
    end else if (en) begin
      w_issue = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= c_IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_data   <= '0;
    end else begin
      r_state     <= w_next_state;
      r_cur_addr  <= w_next_cur;
      r_remaining <= w_next_rem;
      r_s1_valid  <= w_issue;
      r_s1_last   <= w_issue_last;
      if (w_issue) begin
        r_s1_data <= w_rom[w_issue_addr];
      end
    end
  end

  assign busy = (r_state == c_BURST);

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_s2_valid;
      logic                  r_s2_last;
      logic [DATA_WIDTH-1:0] r_s2_data;

      always_ff @(posedge clock) begin
        if (reset) begin
          r_s2_valid <= 1'b0;
          r_s2_last  <= 1'b0;
          r_s2_data  <= '0;
        end else begin
          r_s2_valid <= r_s1_valid;
          r_s2_last  <= r_s1_valid & r_s1_last;
          if (r_s1_valid) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign rom_out    = r_s2_data;
      assign rom_valid  = r_s2_valid;
      assign burst_done = r_s2_valid & r_s2_last;
    end else begin : g_out_direct
      assign rom_out    = r_s1_data;
      assign rom_valid  = r_s1_valid;
      assign burst_done = r_s1_valid & r_s1_last;
    end
  endgenerate

endmodule
`default_nettype wire
